// File: rtl/wb_pkg.sv
// Shared write-back constants and types for the ASIP datapath.
// Reused by the write-back arbiter, decoder and register-file blocks.
package wb_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_SELECT = 1'b0;
  localparam mode_t MODE_RR     = 1'b1;

  localparam int WB_WIDTH   = 8;
  localparam int WB_NUM_SRC = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping from N-1 back to 0.
module rr_priority_pick
  import wb_pkg::*;
#(
  parameter int N  = WB_NUM_SRC,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int idx;
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx -= N;
      if (!any_grant && req[idx]) begin
        any_grant         = 1'b1;
        grant_idx         = IW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_source_arbiter.sv
// Registered NUM_SRC:1 write-back source selector with select
// and round-robin modes feeding the register-file write port.
module wb_source_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  input  mode_t                    mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             sel_err_q, sel_err_d;

  logic [NUM_SRC-1:0] rr_oh, gnt_oh;
  logic [SEL_W-1:0]   rr_idx, gnt_idx;
  logic               rr_any, gnt_any;
  logic               accept, xfer, sel_ok;
  logic [31:0]        sel_ext;

  assign sel_ext = 32'(sel);
  assign sel_ok  = sel_ext < 32'(NUM_SRC);

  rr_priority_pick #(
    .N  (NUM_SRC),
    .IW (SEL_W)
  ) u_pick (
    .req          (src_valid),
    .ptr          (rr_ptr_q),
    .grant_onehot (rr_oh),
    .grant_idx    (rr_idx),
    .any_grant    (rr_any)
  );

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = sel;
    gnt_any = 1'b0;
    if (mode == MODE_RR) begin
      gnt_oh  = rr_oh;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else if (sel_ok && src_valid[sel]) begin
      gnt_oh[sel] = 1'b1;
      gnt_any     = 1'b1;
    end
  end

  // A drain and a new load may share one edge.
  assign accept    = !out_valid_q || out_ready;
  assign xfer      = accept && gnt_any;
  assign src_ready = (accept && rst_n) ? gnt_oh : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    sel_err_d   = sel_err_q | (mode == MODE_SELECT && !sel_ok);
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = src_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_src_d   = gnt_idx;
      rr_ptr_d    = (gnt_idx == SEL_W'(NUM_SRC-1)) ? '0
                                                   : gnt_idx + SEL_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel_err   = sel_err_q;

endmodule
